// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, instruction address and IF/ID capture for the 16-bit CPU.
// Optional FETCH_COUNT_EN adds a saturating count of captured instructions.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          MEM_BYTES   = 1024,
    parameter logic [3:0]  HALT_OPCODE = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic [15:0] ins_in,
    output logic [15:0] pc_out,
    output logic [15:0] ifid_ins,
    output logic [15:0] ifid_pc,
    output logic        ifid_valid,
`ifdef FETCH_COUNT_EN
    output logic [15:0] fetch_count,
`endif
    output logic        halted
);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HALT = 1'b1;

    // Redirect targets are masked into the memory window and forced to a word boundary.
    localparam logic [15:0] ADDR_MASK = 16'(MEM_BYTES - 1) & 16'hFFFE;
    localparam logic [15:0] WRAP_PC   = 16'(MEM_BYTES - 2);

    logic        state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ins_q, ins_d;
    logic [15:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        capture;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ins_d    = ins_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        capture  = 1'b0;
        if (state_q == ST_HALT) begin
            // halted rises together with the valid drop, after the halt word was presented.
            valid_d  = 1'b0;
            halted_d = 1'b1;
        end else if (redirect) begin
            pc_d    = redirect_pc & ADDR_MASK;
            valid_d = 1'b0;
        end else if (!stall) begin
            capture = 1'b1;
            ins_d   = ins_in;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = (pc_q == WRAP_PC) ? 16'h0000 : pc_q + 16'd2;
            if (ins_in[15:12] == HALT_OPCODE) begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            ins_q    <= 16'h0000;
            ipc_q    <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ins_q    <= ins_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (capture && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch_count = count_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

    assign pc_out     = pc_q;
    assign ifid_ins   = ins_q;
    assign ifid_pc    = ipc_q;
    assign ifid_valid = valid_q;
    assign halted     = halted_q;

endmodule
